// File: rtl/alu_pkg.sv
// Shared ALU encodings, MIPS opcode/funct constants and the decoded-control record
// passed from the decoder into the issue register.
package alu_pkg;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic [3:0] aluop;
    logic       is_signed;
    logic [4:0] dest;
    logic       reg_we;
    logic       reserved;
  } ctl_t;
endpackage

// File: rtl/id_alu_decode.sv
// Combinational decode of one MIPS ALU instruction into ALU controls and final operands.
module id_alu_decode
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] rs_value,
  input  logic [DATA_WIDTH-1:0] rt_value,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output ctl_t                  ctl
);
  logic [5:0]            opcode, funct;
  logic [4:0]            rt, rd, shamt;
  logic [DATA_WIDTH-1:0] imm_sext, imm_zext, shamt_ext;
  logic                  ok;
  logic                  unused_rs;

  assign opcode    = inst[31:26];
  assign funct     = inst[5:0];
  assign rt        = inst[20:16];
  assign rd        = inst[15:11];
  assign shamt     = inst[10:6];
  assign imm_sext  = {{(DATA_WIDTH-16){inst[15]}}, inst[15:0]};
  assign imm_zext  = {{(DATA_WIDTH-16){1'b0}}, inst[15:0]};
  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, shamt};
  assign unused_rs = ^inst[25:21];

  always_comb begin
    ok    = 1'b1;
    ctl   = '0;
    alu_a = rs_value;
    alu_b = rt_value;
    if (opcode == OP_SPECIAL) begin
      ctl.dest = rd;
      case (funct)
        F_ADD:  begin ctl.aluop = ALU_ADD; ctl.is_signed = 1'b1; end
        F_ADDU: ctl.aluop = ALU_ADD;
        F_SUB:  begin ctl.aluop = ALU_SUB; ctl.is_signed = 1'b1; end
        F_SUBU: ctl.aluop = ALU_SUB;
        F_AND:  ctl.aluop = ALU_AND;
        F_OR:   ctl.aluop = ALU_OR;
        F_XOR:  ctl.aluop = ALU_XOR;
        F_NOR:  ctl.aluop = ALU_NOR;
        F_SLT:  ctl.aluop = ALU_SLT;
        F_SLTU: ctl.aluop = ALU_SLTU;
        F_SLL:  begin ctl.aluop = ALU_SLL; alu_a = shamt_ext; end
        F_SRL:  begin ctl.aluop = ALU_SRL; alu_a = shamt_ext; end
        F_SRA:  begin ctl.aluop = ALU_SRA; alu_a = shamt_ext; end
        F_SLLV: ctl.aluop = ALU_SLL;
        F_SRLV: ctl.aluop = ALU_SRL;
        F_SRAV: ctl.aluop = ALU_SRA;
        default: ok = 1'b0;
      endcase
    end else begin
      ctl.dest = rt;
      alu_b    = imm_sext;
      case (opcode)
        OP_ADDI:  begin ctl.aluop = ALU_ADD; ctl.is_signed = 1'b1; end
        OP_ADDIU: ctl.aluop = ALU_ADD;
        OP_SLTI:  ctl.aluop = ALU_SLT;
        OP_SLTIU: ctl.aluop = ALU_SLTU;
        OP_ANDI:  begin ctl.aluop = ALU_AND; alu_b = imm_zext; end
        OP_ORI:   begin ctl.aluop = ALU_OR;  alu_b = imm_zext; end
        OP_XORI:  begin ctl.aluop = ALU_XOR; alu_b = imm_zext; end
        OP_LUI:   begin ctl.aluop = ALU_LUI; alu_a = '0; alu_b = imm_zext; end
        default:  ok = 1'b0;
      endcase
    end
    // Unsupported encodings collapse to a harmless AND 0,0 with no writeback.
    if (!ok) begin
      ctl          = '0;
      ctl.reserved = 1'b1;
      alu_a        = '0;
      alu_b        = '0;
    end else begin
      ctl.reg_we = (ctl.dest != 5'd0);
    end
  end
endmodule

// File: rtl/id_alu_issue.sv
// Single-entry decode/issue register between ID and the EX-stage ALU with valid/ready,
// stall and flush.
module id_alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs_value,
  input  logic [DATA_WIDTH-1:0] in_rt_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_a,
  output logic [DATA_WIDTH-1:0] out_alu_b,
  output logic [3:0]            out_aluop,
  output logic                  out_is_signed,
  output logic [4:0]            out_dest,
  output logic                  out_reg_we,
  output logic                  out_reserved,
  output logic [DATA_WIDTH-1:0] out_pc
);
  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  ctl_t                  dec_ctl, ctl_q;
  logic                  accept;

  id_alu_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .inst     (in_inst),
    .rs_value (in_rs_value),
    .rt_value (in_rt_value),
    .alu_a    (dec_a),
    .alu_b    (dec_b),
    .ctl      (dec_ctl)
  );

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Payload only moves on accept so a stalled entry stays bit-stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_alu_a <= '0;
      out_alu_b <= '0;
      out_pc    <= '0;
      ctl_q     <= '0;
    end else begin
      if (accept) begin
        out_alu_a <= dec_a;
        out_alu_b <= dec_b;
        out_pc    <= in_pc;
        ctl_q     <= dec_ctl;
      end
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  assign out_aluop     = ctl_q.aluop;
  assign out_is_signed = ctl_q.is_signed;
  assign out_dest      = ctl_q.dest;
  assign out_reg_we    = ctl_q.reg_we;
  assign out_reserved  = ctl_q.reserved;
endmodule

// File: tb/tb_id_alu_issue.sv
// Randomized + directed bench for id_alu_issue against a behavioural decode/handshake model.
module tb_id_alu_issue;
  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, in_rs_value, in_rt_value;
  logic [31:0] out_alu_a, out_alu_b, out_pc;
  logic [3:0]  out_aluop;
  logic        out_is_signed, out_reg_we, out_reserved;
  logic [4:0]  out_dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_alu_issue #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs_value(in_rs_value), .in_rt_value(in_rt_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_aluop(out_aluop),
    .out_is_signed(out_is_signed), .out_dest(out_dest), .out_reg_we(out_reg_we),
    .out_reserved(out_reserved), .out_pc(out_pc)
  );

  typedef struct packed {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        sg;
    logic [4:0]  dest;
    logic        we, rsv;
  } dec_t;

  dec_t        m;
  logic [31:0] m_pc;
  logic        m_valid;

  // What the ALU must be told for one instruction, straight from the ISA table.
  function automatic dec_t mdec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    dec_t d;
    logic ok;
    logic [31:0] se, ze;
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    ok = 1'b1;
    d = '0;
    d.a = rs;
    if (i[31:26] == 6'h00) begin
      d.b = rt;
      d.dest = i[15:11];
      case (i[5:0])
        6'h20: begin d.op = 4'b0010; d.sg = 1'b1; end
        6'h21: d.op = 4'b0010;
        6'h22: begin d.op = 4'b0110; d.sg = 1'b1; end
        6'h23: d.op = 4'b0110;
        6'h24: d.op = 4'b0000;
        6'h25: d.op = 4'b0001;
        6'h26: d.op = 4'b1010;
        6'h27: d.op = 4'b1001;
        6'h2A: d.op = 4'b0111;
        6'h2B: d.op = 4'b0100;
        6'h00: begin d.op = 4'b0101; d.a = 32'(i[10:6]); end
        6'h02: begin d.op = 4'b1100; d.a = 32'(i[10:6]); end
        6'h03: begin d.op = 4'b1011; d.a = 32'(i[10:6]); end
        6'h04: d.op = 4'b0101;
        6'h06: d.op = 4'b1100;
        6'h07: d.op = 4'b1011;
        default: ok = 1'b0;
      endcase
    end else begin
      d.dest = i[20:16];
      case (i[31:26])
        6'h08: begin d.op = 4'b0010; d.sg = 1'b1; d.b = se; end
        6'h09: begin d.op = 4'b0010; d.b = se; end
        6'h0A: begin d.op = 4'b0111; d.b = se; end
        6'h0B: begin d.op = 4'b0100; d.b = se; end
        6'h0C: begin d.op = 4'b0000; d.b = ze; end
        6'h0D: begin d.op = 4'b0001; d.b = ze; end
        6'h0E: begin d.op = 4'b1010; d.b = ze; end
        6'h0F: begin d.op = 4'b0011; d.a = 32'h0; d.b = ze; end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      d = '0;
      d.rsv = 1'b1;
    end else begin
      d.we = (d.dest != 5'd0);
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("alu_a", out_alu_a, m.a);
    chk("alu_b", out_alu_b, m.b);
    chk("aluop", 32'(out_aluop), 32'(m.op));
    chk("is_signed", 32'(out_is_signed), 32'(m.sg));
    chk("reg_we", 32'(out_reg_we), 32'(m.we));
    chk("reserved", 32'(out_reserved), 32'(m.rsv));
    chk("pc", out_pc, m_pc);
    if (!m.rsv) chk("dest", 32'(out_dest), 32'(m.dest));
  endtask

  // One cycle: drive after negedge, check in_ready, model the edge, compare at next negedge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic ordy, input logic fl);
    logic acc;
    in_valid = v; in_inst = inst; in_pc = pc; in_rs_value = rs; in_rt_value = rt;
    out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!fl && (!m_valid || ordy)));
    @(posedge clk);
    acc = v && !fl && (!m_valid || ordy);
    if (acc) begin
      m = mdec(inst, rs, rt);
      m_pc = pc;
      m_valid = 1'b1;
    end else if (fl || ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fl [16];
    logic [31:0] r;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    r = $urandom;
    case ($urandom_range(0, 3))
      0: rand_inst = r;
      1: rand_inst = {6'h00, r[25:6], fl[$urandom_range(0, 15)]};
      2: rand_inst = {6'(8 + $urandom_range(0, 7)), r[25:0]};
      default: rand_inst = {6'h00, r[25:6], 6'($urandom_range(0, 63))};
    endcase
  endfunction

  initial begin
    dec_t p;
    m = '0; m_pc = '0; m_valid = 1'b0;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_rs_value = '0; in_rt_value = '0;

    // Model pinned against hand-computed ISA results.
    p = mdec(32'h20A3FFFF, 32'd5, 32'd9);
    chk("model_addi_b", p.b, 32'hFFFFFFFF);
    p = mdec(32'h34E78000, 32'd1, 32'd2);
    chk("model_ori_b", p.b, 32'h00008000);

    @(negedge clk);
    compare_all();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    step(1'b1, 32'h20A3FFFF, 32'h100, 32'd5, 32'd77, 1'b1, 1'b0);
    chk("addi_a", out_alu_a, 32'd5);
    chk("addi_b", out_alu_b, 32'hFFFFFFFF);
    chk("addi_op", 32'(out_aluop), 32'h2);
    chk("addi_sg", 32'(out_is_signed), 32'd1);
    chk("addi_dest", 32'(out_dest), 32'd3);
    chk("addi_we", 32'(out_reg_we), 32'd1);

    step(1'b1, 32'h00041100, 32'h104, 32'hDEAD, 32'h1, 1'b1, 1'b0);
    chk("sll_a", out_alu_a, 32'd4);
    chk("sll_b", out_alu_b, 32'd1);
    chk("sll_op", 32'(out_aluop), 32'h5);

    step(1'b1, 32'h00000000, 32'h108, 32'h3, 32'h4, 1'b1, 1'b0);
    chk("nop_we", 32'(out_reg_we), 32'd0);
    chk("nop_rsv", 32'(out_reserved), 32'd0);

    step(1'b1, 32'h3C071234, 32'h10C, 32'h55, 32'h66, 1'b1, 1'b0);
    chk("lui_a", out_alu_a, 32'h0);
    chk("lui_b", out_alu_b, 32'h00001234);
    step(1'b1, 32'h34E78000, 32'h110, 32'h12340000, 32'h0, 1'b1, 1'b0);
    chk("ori_b", out_alu_b, 32'h00008000);

    // Back-pressure: ORI entry must sit still for 3 cycles, then the waiting one issues.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h01095020, 32'h114, 32'h7, 32'h8, 1'b0, 1'b0);
      chk("stall_pc", out_pc, 32'h110);
    end
    step(1'b1, 32'h01095020, 32'h114, 32'h7, 32'h8, 1'b1, 1'b0);
    chk("release_pc", out_pc, 32'h114);
    chk("release_valid", 32'(out_valid), 32'd1);

    step(1'b1, 32'h01095021, 32'h118, 32'h7, 32'h8, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_pc", out_pc, 32'h114);

    step(1'b1, 32'hFC000000, 32'h11C, 32'h1, 32'h2, 1'b1, 1'b0);
    chk("rsv_op_rsv", 32'(out_reserved), 32'd1);
    chk("rsv_op_we", 32'(out_reg_we), 32'd0);
    step(1'b1, 32'h0000003F, 32'h120, 32'h1, 32'h2, 1'b1, 1'b0);
    chk("rsv_fn_rsv", 32'(out_reserved), 32'd1);
    chk("rsv_fn_we", 32'(out_reg_we), 32'd0);

    // Asynchronous reset during a stall drops the entry before the next edge.
    step(1'b1, 32'h20A3FFFF, 32'h124, 32'h5, 32'h0, 1'b1, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_a", out_alu_a, 32'd0);
    m = '0; m_pc = '0; m_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 3) != 0), rand_inst(), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/id_alu_issue.md
# id_alu_issue

Decode-and-issue register between the instruction-decode stage and the execute-stage ALU of the MIPS pipeline. Accepts a fetched instruction with its register-file read values, decodes it into ALU controls (ALUop, is_signed) and final operands A/B, and holds them in a single-entry pipeline register with a valid/ready handshake toward execute. Supports stall (back-pressure) and flush, and flags unsupported encodings as reserved-instruction.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC width

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill held entry and block input this cycle
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  this block accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  DATA_WIDTH  instruction PC
- in_rs_value  in  DATA_WIDTH  GPR[rs]
- in_rt_value  in  DATA_WIDTH  GPR[rt]
- out_valid  out  1  entry held for execute
- out_ready  in  1  execute consumes this cycle
- out_alu_a  out  DATA_WIDTH  ALU operand A
- out_alu_b  out  DATA_WIDTH  ALU operand B
- out_aluop  out  4  ALU operation code
- out_is_signed  out  1  enables ALU overflow detection
- out_dest  out  5  destination GPR index
- out_reg_we  out  1  GPR write enable
- out_reserved  out  1  reserved-instruction exception
- out_pc  out  DATA_WIDTH  registered PC

## Operation
- ALUop codes: AND 0000, OR 0001, ADD 0010, LUI 0011, SLTU 0100, SLL 0101, SUB 0110, SLT 0111, NOR 1001, XOR 1010, SRA 1011, SRL 1100.
- R-type (opcode 0), funct → aluop/is_signed: 0x20 ADD/1, 0x21 ADD/0, 0x22 SUB/1, 0x23 SUB/0, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLL, 0x06 SRL, 0x07 SRA. is_signed=0 except where noted.
- R-type operands: A=rs_value, B=rt_value; immediate shifts (0x00/0x02/0x03) A={27'b0,shamt}; variable shifts A=rs_value; dest=rd.
- I-type: 0x08 ADD/1, 0x09 ADD/0, 0x0A SLT, 0x0B SLTU, 0x0C AND, 0x0D OR, 0x0E XOR, 0x0F LUI. A=rs_value (LUI: A=0), dest=rt.
- Immediate: sign-extended for 0x08–0x0B (SLTIU compares the sign-extended value unsigned); zero-extended for 0x0C–0x0F.
- Any other opcode/funct: out_reserved=1, aluop=AND, is_signed=0, reg_we=0, A=B=0.
- out_reg_we = supported && dest≠0 (so NOP 0x00000000 has reg_we=0, reserved=0).

## Timing
- Reset: out_valid=0; all data/control outputs 0; in_ready follows its equation.
- in_ready = !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Latency 1 cycle: decoded outputs valid the cycle after accept; throughput 1/cycle under continuous out_ready.
- Accept: register updates, out_valid←1. Consume without accept: out_valid←0. Simultaneous consume+accept: replace entry, out_valid stays 1.
- Stall (out_valid && !out_ready): all out_* held bit-stable, in_ready=0.
- flush: out_valid←0 next edge regardless of out_ready/in_valid; no input accepted that cycle.
- Data registers update only on accept; out_valid is the sole qualifier.
- resetn low mid-stall: out_valid cleared asynchronously, held entry lost.

## Structure
- Shared package alu_pkg: ALUop constants, opcode and funct constants, DATA_WIDTH default.
- One combinational sub-module id_alu_decode (inst, rs_value, rt_value → aluop, is_signed, A, B, dest, reg_we, reserved); top holds the pipeline register and handshake.

## Test plan
- addi $3,$5,-1 (0x20A3FFFF), rs=5 → A=5, B=0xFFFFFFFF, aluop 0010, is_signed 1, dest 3, reg_we 1, one cycle later.
- sll $2,$4,4 (0x00041100), rt=0x1 → A=4, B=0x1, aluop 0101; NOP 0x00000000 → reg_we 0, reserved 0.
- lui $7,0x1234 and ori $7,$7,0x8000 → LUI: A=0, B=0x00001234; ORI: B=0x00008000 (zero-extended).
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable; release → next instruction issued the following cycle, none lost/duplicated.
- flush asserted with out_valid=1, out_ready=0, in_valid=1 → out_valid=0 next cycle, input not accepted.
- opcode 0x3F and R-type funct 0x3F → reserved 1, reg_we 0; resetn pulse during stall → out_valid 0 immediately.
